// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum trailer is enabled with IMEM_LOADER_CKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    CHECK = 3'd3,
    DATA  = 3'd4,
    SUM   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         ADDR_BYTES = 4;
  localparam int         LEN_BYTES  = 2;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_CKSUM = 2'd3;

  // True when base+len (no wrap) runs past the byte capacity.
  function automatic logic exceeds_cap(input logic [31:0] base,
                                       input logic [15:0] len,
                                       input logic [32:0] cap);
    logic [32:0] end_s;
    end_s = {1'b0, base} + {17'd0, len};
    return (end_s > cap);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: writes a program image into instruction memory
// and releases the core from reset after a clean load. Optional checksum: IMEM_LOADER_CKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [32:0] CAP = 33'(4 * DEPTH_WORDS);
  localparam logic [1:0]  ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0]  LEN_LAST  = 2'(LEN_BYTES - 1);

  state_e      state_r;
  logic [31:0] base_r;
  logic [15:0] len_r;
  logic [15:0] cnt_r;
  logic [1:0]  hdr_cnt_r;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  csum_r;
`endif

  logic accept_s;
  logic sync_s;
  logic last_s;
  logic range_err_s;

  assign accept_s    = s_valid & s_ready;
  assign sync_s      = accept_s & (s_data == SYNC_BYTE);
  assign last_s      = (cnt_r == (len_r - 16'd1));
  assign range_err_s = exceeds_cap(base_r, len_r, CAP);

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= 32'd0;
      len_r      <= 16'd0;
      cnt_r      <= 16'd0;
      hdr_cnt_r  <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_r     <= 8'd0;
`endif
      s_ready    <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 8'd0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        // ERR drains like IDLE but keeps the sticky flag until a new sync byte.
        IDLE, ERR: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          if (sync_s) begin
            state_r    <= ADDR;
            hdr_cnt_r  <= 2'd0;
            cnt_r      <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            csum_r     <= 8'd0;
`endif
            core_rst_n <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
          end else begin
            state_r <= state_r;
          end
        end

        ADDR: begin
          if (accept_s) begin
            base_r <= {base_r[23:0], s_data};
            if (hdr_cnt_r == ADDR_LAST) begin
              hdr_cnt_r <= 2'd0;
              state_r   <= LEN;
            end else begin
              hdr_cnt_r <= hdr_cnt_r + 2'd1;
            end
          end else begin
            state_r <= ADDR;
          end
        end

        LEN: begin
          if (accept_s) begin
            len_r <= {len_r[7:0], s_data};
            if (hdr_cnt_r == LEN_LAST) begin
              hdr_cnt_r <= 2'd0;
              s_ready   <= 1'b0;
              state_r   <= CHECK;
            end else begin
              hdr_cnt_r <= hdr_cnt_r + 2'd1;
            end
          end else begin
            state_r <= LEN;
          end
        end

        // Alignment outranks range; an empty image skips DATA entirely.
        CHECK: begin
          if (base_r[1:0] != 2'b00) begin
            state_r  <= ERR;
            s_ready  <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_ALIGN;
            busy     <= 1'b0;
          end else if (range_err_s) begin
            state_r  <= ERR;
            s_ready  <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_RANGE;
            busy     <= 1'b0;
          end else if (len_r == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_r <= SUM;
            s_ready <= 1'b1;
`else
            state_r <= DONE;
            s_ready <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            state_r <= DATA;
            cnt_r   <= 16'd0;
            s_ready <= 1'b1;
          end
        end

        DATA: begin
          if (accept_s) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_r + {16'd0, cnt_r};
            mem_wdata <= s_data;
            cnt_r     <= cnt_r + 16'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            csum_r    <= csum_r ^ s_data;
`endif
            if (last_s) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state_r <= SUM;
`else
              state_r <= DONE;
              s_ready <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              state_r <= DATA;
            end
          end else begin
            state_r <= DATA;
          end
        end

`ifdef IMEM_LOADER_CKSUM_EN
        SUM: begin
          if (accept_s) begin
            if (s_data == csum_r) begin
              state_r <= DONE;
              s_ready <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r  <= ERR;
              err      <= 1'b1;
              err_code <= ERR_CKSUM;
              busy     <= 1'b0;
            end
          end else begin
            state_r <= SUM;
          end
        end
`endif

        DONE: begin
          state_r    <= IDLE;
          s_ready    <= 1'b1;
          core_rst_n <= 1'b1;
          busy       <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CKSUM_EN when defined.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          acc_n = 0;
  int          acc_cyc [0:1023];
  int          wr_n = 0;
  logic [31:0] wr_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          wr_cyc  [0:255];
  int          done_n = 0;
  logic [7:0]  pl [0:15];

  imem_loader #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Record the cycle of every accepted byte.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && s_valid && s_ready) begin
      acc_cyc[acc_n] = cyc;
      acc_n = acc_n + 1;
    end
  end

  // Capture memory writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_n < 256) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
    if (done === 1'b1) done_n = done_n + 1;
  end

  // Called at a negedge; returns at the negedge after the byte is taken, s_valid still high.
  task automatic send(input logic [7:0] b);
    int n;
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 64) begin
      bad++;
      $display("FAIL send_timeout byte=%h got s_ready=%b want 1", b, s_ready);
    end
    @(negedge clk);
  endtask

  task automatic hdr(input logic [31:0] base, input logic [15:0] len);
    send(8'hA5);
    send(base[31:24]); send(base[23:16]); send(base[15:8]); send(base[7:0]);
    send(len[15:8]);   send(len[7:0]);
  endtask

  task automatic payload(input int len, input bit gap);
    for (int i = 0; i < len; i++) begin
      send(pl[i]);
      if (gap) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic send_ck(input int len);
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < len; i++) x = x ^ pl[i];
    send(x);
`else
    if (len < 0) $display("negative length %0d", len);
`endif
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    total++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, err_code} !==
        {1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b code=%0d",
               s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, err_code);
    end
  endtask

  task automatic test_basic;
    int w0, d0;
    logic [7:0] exp_d [0:7];
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};
    for (int i = 0; i < 8; i++) pl[i] = exp_d[i];
    w0 = wr_n; d0 = done_n;
    hdr(32'h0000_0000, 16'd8);
    total++;
    if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
      bad++; $display("FAIL basic_busy got busy=%b crst=%b want 1 0", busy, core_rst_n);
    end
    payload(8, 1'b0);
    send_ck(8);
    idle(4);
    total++;
    if (wr_n - w0 !== 8) begin
      bad++; $display("FAIL basic_wcount got=%0d want=8", wr_n - w0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (wr_addr[w0+i] !== 32'(i) || wr_data[w0+i] !== exp_d[i]) begin
          bad++; $display("FAIL basic_write[%0d] got a=%h d=%h want a=%h d=%h",
                          i, wr_addr[w0+i], wr_data[w0+i], 32'(i), exp_d[i]);
        end
      end
    end
    total++;
    if (done_n - d0 !== 1 || core_rst_n !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL basic_done got done=%0d crst=%b busy=%b err=%b want 1 1 0 0",
                      done_n - d0, core_rst_n, busy, err);
    end
  endtask

  task automatic test_align;
    int w0, d0;
    w0 = wr_n; d0 = done_n;
    hdr(32'h0000_0002, 16'd4);
    idle(3);
    total++;
    if (err !== 1'b1 || err_code !== 2'd1 || wr_n != w0 || core_rst_n !== 1'b0 ||
        busy !== 1'b0 || s_ready !== 1'b1 || done_n != d0) begin
      bad++; $display("FAIL align_err got err=%b code=%0d wr=%0d crst=%b busy=%b rdy=%b want 1 1 0 0 0 1",
                      err, err_code, wr_n - w0, core_rst_n, busy, s_ready);
    end
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    hdr(32'h0000_0010, 16'd2);
    total++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      bad++; $display("FAIL align_clear got err=%b code=%0d want 0 0", err, err_code);
    end
    payload(2, 1'b0);
    send_ck(2);
    idle(4);
    total++;
    if (wr_n - w0 !== 2 || wr_addr[w0] !== 32'h10 || wr_data[w0] !== 8'hAA ||
        wr_addr[w0+1] !== 32'h11 || wr_data[w0+1] !== 8'hBB) begin
      bad++; $display("FAIL align_reload_writes got n=%0d a0=%h d0=%h a1=%h d1=%h want 2 10 aa 11 bb",
                      wr_n - w0, wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]);
    end
    total++;
    if (done_n - d0 !== 1 || core_rst_n !== 1'b1) begin
      bad++; $display("FAIL align_reload_done got done=%0d crst=%b want 1 1", done_n - d0, core_rst_n);
    end
  endtask

  task automatic test_range;
    int w0, d0;
    w0 = wr_n; d0 = done_n;
    hdr(32'h0000_0FFC, 16'd5);
    idle(3);
    total++;
    if (err !== 1'b1 || err_code !== 2'd2 || wr_n != w0 || core_rst_n !== 1'b0) begin
      bad++; $display("FAIL range_err got err=%b code=%0d wr=%0d crst=%b want 1 2 0 0",
                      err, err_code, wr_n - w0, core_rst_n);
    end
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    hdr(32'h0000_0FFC, 16'd4);
    payload(4, 1'b0);
    send_ck(4);
    idle(4);
    total++;
    if (wr_n - w0 !== 4) begin
      bad++; $display("FAIL range_edge_count got=%0d want=4", wr_n - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_addr[w0+i] !== 32'h0FFC + 32'(i) || wr_data[w0+i] !== pl[i]) begin
          bad++; $display("FAIL range_edge_write[%0d] got a=%h d=%h want a=%h d=%h",
                          i, wr_addr[w0+i], wr_data[w0+i], 32'h0FFC + 32'(i), pl[i]);
        end
      end
    end
    total++;
    if (done_n - d0 !== 1 || err !== 1'b0 || core_rst_n !== 1'b1) begin
      bad++; $display("FAIL range_edge_done got done=%0d err=%b crst=%b want 1 0 1",
                      done_n - d0, err, core_rst_n);
    end
  endtask

  task automatic test_drop_len0;
    int w0, d0;
    w0 = wr_n; d0 = done_n;
    send(8'h11);
    send(8'h22);
    hdr(32'h0000_0010, 16'd0);
    total++;
    if (core_rst_n !== 1'b0) begin
      bad++; $display("FAIL reload_core_rst got=%b want=0", core_rst_n);
    end
    send_ck(0);
    idle(4);
    total++;
    if (done_n - d0 !== 1 || wr_n != w0 || err !== 1'b0 || core_rst_n !== 1'b1) begin
      bad++; $display("FAIL len0_done got done=%0d wr=%0d err=%b crst=%b want 1 0 0 1",
                      done_n - d0, wr_n - w0, err, core_rst_n);
    end
  endtask

  task automatic test_toggle;
    int w0, a0, d0;
    pl[0] = 8'h05; pl[1] = 8'h06; pl[2] = 8'h07; pl[3] = 8'h08;
    d0 = done_n;
    hdr(32'h0000_0020, 16'd4);
    a0 = acc_n; w0 = wr_n;
    payload(4, 1'b1);
    send_ck(4);
    idle(4);
    total++;
    if (wr_n - w0 !== 4 || done_n - d0 !== 1) begin
      bad++; $display("FAIL toggle_count got wr=%0d done=%0d want 4 1", wr_n - w0, done_n - d0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_addr[w0+i] !== 32'h20 + 32'(i) || wr_data[w0+i] !== pl[i] ||
            wr_cyc[w0+i] !== acc_cyc[a0+i]) begin
          bad++; $display("FAIL toggle_write[%0d] got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d",
                          i, wr_addr[w0+i], wr_data[w0+i], wr_cyc[w0+i],
                          32'h20 + 32'(i), pl[i], acc_cyc[a0+i]);
        end
      end
    end
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  task automatic test_cksum;
    int w0, d0;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    d0 = done_n;
    hdr(32'h0000_0000, 16'd4);
    payload(4, 1'b0);
    send(8'h04);
    idle(4);
    total++;
    if (done_n - d0 !== 1 || err !== 1'b0 || core_rst_n !== 1'b1) begin
      bad++; $display("FAIL cksum_good got done=%0d err=%b crst=%b want 1 0 1", done_n - d0, err, core_rst_n);
    end
    w0 = wr_n; d0 = done_n;
    hdr(32'h0000_0000, 16'd4);
    payload(4, 1'b0);
    send(8'h05);
    idle(4);
    total++;
    if (err !== 1'b1 || err_code !== 2'd3 || wr_n - w0 !== 4 || core_rst_n !== 1'b0 || done_n != d0) begin
      bad++; $display("FAIL cksum_bad got err=%b code=%0d wr=%0d crst=%b done=%0d want 1 3 4 0 0",
                      err, err_code, wr_n - w0, core_rst_n, done_n - d0);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int d0;
    pl[0] = 8'h5A; pl[1] = 8'h6B;
    hdr(32'h0000_0040, 16'd4);
    send(pl[0]);
    send(pl[1]);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, err_code} !==
        {1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL midreset_outputs got rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b code=%0d",
               s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, err_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_n;
    hdr(32'h0000_0000, 16'd0);
    send_ck(0);
    idle(4);
    total++;
    if (done_n - d0 !== 1 || core_rst_n !== 1'b1) begin
      bad++; $display("FAIL midreset_restart got done=%0d crst=%b want 1 1", done_n - d0, core_rst_n);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_align;
    test_range;
    test_drop_len0;
    test_toggle;
`ifdef IMEM_LOADER_CKSUM_EN
    test_cksum;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader; the write side of the byte-addressed instruction memory.
- Accepts a framed program image over a valid/ready byte stream.
- Writes payload bytes into the instruction memory byte array, MSB-first per word: the byte at addr is inst[31:24].
- Holds the core in reset until a full image has loaded without error.

Parameters:
- DEPTH_WORDS, 1024: instruction memory depth in 32-bit words. Byte capacity is CAP = 4*DEPTH_WORDS.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_ready  out  1  loader can accept byte
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  32  byte address of write
- mem_wdata  out  8  byte to write
- core_rst_n  out  1  active-low reset to the core (0 = hold in reset)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on successful load
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 misaligned base, 2 out of range, 3 checksum

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rst_n=0, busy=0, done=0, err=0, err_code=0.
  - State IDLE; all counters 0.
  - Reset mid-frame abandons the frame; bytes already written stay in memory.
- Handshake: a byte is accepted when s_valid && s_ready at a rising clk edge.
- Frame: SYNC 8'hA5, BASE (4 bytes, MSB first), LEN (2 bytes, MSB first, payload byte count), then LEN payload bytes.
- IDLE:
  - s_ready=1.
  - Non-sync bytes are dropped.
  - Sync byte -> ADDR; core_rst_n<=0, busy<=1, err<=0, err_code<=0.
- ADDR: s_ready=1; shift in 4 bytes, then -> LEN.
- LEN: s_ready=1; shift in 2 bytes, then -> CHECK.
- CHECK: one cycle, s_ready=0. Checks in priority order:
  - BASE[1:0]!=0 -> ERR, code 1.
  - Else {1'b0,BASE}+LEN > CAP, computed in 33 bits with no wrap -> ERR, code 2.
  - Else LEN==0 -> DONE (or SUM if checksum is enabled).
  - Else -> DATA with cnt=0.
- DATA:
  - s_ready=1.
  - Each accepted byte registers mem_we=1, mem_addr=BASE+cnt, mem_wdata=byte on the next cycle (latency 1).
  - cnt increments per accepted byte.
  - mem_we=0 in any cycle with no acceptance.
  - After byte LEN-1 -> DONE (or SUM).
- DONE:
  - One cycle, s_ready=0, done=1.
  - core_rst_n<=1 at exit; busy<=0.
  - -> IDLE.
- ERR:
  - s_ready=1 (drain); err=1 and err_code held.
  - core_rst_n stays 0, busy<=0.
  - Sync byte -> ADDR and starts a new frame (clears err).
- A sync byte value inside ADDR/LEN/DATA is ordinary data; there is no resync.
- s_valid deasserted mid-frame: the state holds indefinitely; no timeout.
- A reload after a successful load drops core_rst_n on acceptance of the new sync byte.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined:
  - State SUM follows DATA (or CHECK when LEN==0).
  - SUM: s_ready=1; accepts one byte.
  - The byte must equal the XOR of all payload bytes (0x00 for LEN==0).
  - Match -> DONE. Mismatch -> ERR, code 3. Payload writes are not undone; core_rst_n stays 0.
- Undefined: no SUM state, no checksum byte; code 3 is never produced.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, ADDR, LEN, CHECK, DATA, SUM, DONE, ERR.
  - SYNC_BYTE = 8'hA5.
  - ADDR_BYTES=4, LEN_BYTES=2.
  - err_code localparams: ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_CKSUM.
- No sub-module; the header shift registers and checksum accumulator are inline.

Test Plan:
- Reset release -> core_rst_n=0, s_ready=1. Frame A5 00000000 0008 with payload 00 00 00 13 00 10 00 93 -> 8 mem_we pulses at addr 0..7 carrying those bytes. Then done pulses once and core_rst_n=1.
- Header BASE=0x00000002 -> err=1, err_code=1, no mem_we, core_rst_n=0. A following valid frame clears err.
- BASE=0x00000FFC, LEN=5 (DEPTH_WORDS=1024) -> err_code=2. BASE=0x00000FFC, LEN=4 -> writes at 0xFFC..0xFFF, then done.
- Bytes 11 22 A5 00000010 0000 -> 11 and 22 dropped in IDLE. LEN=0 -> done with zero writes (with checksum enabled, send 00 first).
- s_valid toggled every other cycle during DATA -> mem_we exactly one cycle after each accepted byte, with contiguous addresses.
- With IMEM_LOADER_CKSUM_EN: payload 01 02 03 04 plus checksum 04 -> done. Checksum 05 -> err_code=3, 4 writes done, core_rst_n=0. Also assert rst_n mid-DATA -> all outputs return to reset values immediately.
